// File: rtl/evt_cond_pkg.sv
// Shared types and constants for the event conditioning stage.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package evt_cond_pkg;

    // Debounce FSM: IDLE waits for a difference, QUALIFY holds it for Neff cycles.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        QUALIFY = 1'b1
    } state_e;

    // Edge-select encodings; bit 0 enables rising edges, bit 1 falling edges.
    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // True when a committed edge of the given direction is selected for pulsing.
    function automatic logic edge_selected(input logic [1:0] sel, input logic rising);
        logic hit;
        if (rising) begin
            hit = (sel == EDGE_RISE) || (sel == EDGE_BOTH);
        end else begin
            hit = (sel == EDGE_FALL) || (sel == EDGE_BOTH);
        end
        return hit;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Latency: STAGES clock cycles from capture to output.
// Backpressure: none; the chain samples every cycle.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    generate
        if (STAGES == 1) begin : g_single
            // Single flop: only useful where the input is already quasi-synchronous.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= d_i;
                end
            end
        end else begin : g_multi
            // Shift the raw bit through the chain; bit 0 is the only flop that sees d_i.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[STAGES-2:0], d_i};
                end
            end
        end
    endgenerate

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/event_conditioner.sv
// Synchronises, debounces and edge-detects a raw event line into a one-cycle pulse.
// Latency: level/pulse change SYNC_STAGES + Neff - 1 edges after the first capturing edge.
// Backpressure: none; pulses are fire-and-forget, en_i only gates pulse emission.
module event_conditioner
    import evt_cond_pkg::*;
#(
    parameter int DEBOUNCE_WIDTH = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      evt_i,
    input  logic                      en_i,
    input  logic [1:0]                edge_sel_i,
    input  logic [DEBOUNCE_WIDTH-1:0] debounce_cycles_i,
    output logic                      pulse_o,
    output logic                      level_o,
    output logic                      busy_o
);

    localparam int CW = DEBOUNCE_WIDTH + 1;

    logic                      s_evt;
    logic [DEBOUNCE_WIDTH-1:0] neff;
    logic                      neff_is_one;
    logic [CW-1:0]             cnt_inc;
    logic                      hold_done;
    logic                      commit;

    state_e                    state_q, state_d;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      level_q, level_d;
    logic                      pulse_q, pulse_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (evt_i),
        .q_o   (s_evt)
    );

    // A hold count of zero behaves as one: commit on the first differing sample.
    assign neff        = (debounce_cycles_i == '0) ? DEBOUNCE_WIDTH'(1) : debounce_cycles_i;
    assign neff_is_one = (neff == DEBOUNCE_WIDTH'(1));

    // One extra bit keeps cnt+1 exact; >= lets a lowered hold count commit at once.
    assign cnt_inc   = {1'b0, cnt_q} + CW'(1);
    assign hold_done = (cnt_inc >= {1'b0, neff});

    // Next-state, hold counter and commit/pulse decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s_evt != level_q) begin
                    if (neff_is_one) begin
                        commit = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                        cnt_d   = DEBOUNCE_WIDTH'(1);
                    end
                end
            end
            QUALIFY: begin
                if (s_evt == level_q) begin
                    // Input fell back before the hold expired: a glitch, drop it.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (hold_done) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[DEBOUNCE_WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // The new level gives the edge direction; en/select are sampled only here.
        if (commit) begin
            level_d = ~level_q;
            pulse_d = en_i && edge_selected(edge_sel_i, ~level_q);
        end
    end

    // State, counter, debounced level and registered pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;
    assign busy_o  = (state_q == QUALIFY);

endmodule

// File: tb/tb_event_conditioner.sv
module tb_event_conditioner;

    logic        clk_i;
    logic        rst_i;
    logic        evt_i;
    logic        en_i;
    logic [1:0]  edge_sel_i;
    logic [15:0] debounce_cycles_i;
    logic        pulse_o;
    logic        level_o;
    logic        busy_o;

    int checks;
    int passed;
    int pulse_cnt;

    event_conditioner #(
        .DEBOUNCE_WIDTH (16),
        .SYNC_STAGES    (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .evt_i             (evt_i),
        .en_i              (en_i),
        .edge_sel_i        (edge_sel_i),
        .debounce_cycles_i (debounce_cycles_i),
        .pulse_o           (pulse_o),
        .level_o           (level_o),
        .busy_o            (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stand-in for the downstream counter: increments on every pulse_o cycle.
    initial pulse_cnt = 0;
    always @(negedge clk_i) begin
        if (pulse_o === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; evt_i = 1'b0; en_i = 1'b1; edge_sel_i = 2'b01; debounce_cycles_i = 16'd3;
        tick(3);
        checks++; if (pulse_o !== 1'b0) $display("FAIL reset_pulse: got %b expected 0", pulse_o); else passed++;
        checks++; if (level_o !== 1'b0) $display("FAIL reset_level: got %b expected 0", level_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else passed++;
        rst_i = 1'b0;
        tick(4);
        checks++; if ({busy_o, level_o, pulse_o} !== 3'b000) $display("FAIL idle_after_reset: got %b expected 000", {busy_o, level_o, pulse_o}); else passed++;
    endtask

    task automatic test_basic_rise;
        evt_i = 1'b1;          // next edge is k
        tick(2);               // after k+1
        checks++; if (busy_o !== 1'b0) $display("FAIL rise_busy_k1: got %b expected 0", busy_o); else passed++;
        tick(1);               // after k+2
        checks++; if (busy_o !== 1'b1) $display("FAIL rise_busy_k2: got %b expected 1", busy_o); else passed++;
        tick(1);               // after k+3
        checks++; if (level_o !== 1'b0) $display("FAIL rise_level_k3: got %b expected 0", level_o); else passed++;
        tick(1);               // after k+4
        checks++; if (level_o !== 1'b1) $display("FAIL rise_level_k4: got %b expected 1", level_o); else passed++;
        checks++; if (pulse_o !== 1'b1) $display("FAIL rise_pulse_k4: got %b expected 1", pulse_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL rise_busy_k4: got %b expected 0", busy_o); else passed++;
        tick(1);               // after k+5
        checks++; if (pulse_o !== 1'b0) $display("FAIL rise_pulse_k5: got %b expected 0", pulse_o); else passed++;
        evt_i = 1'b0;
        tick(10);
        checks++; if (level_o !== 1'b0) $display("FAIL rise_return_low: got %b expected 0", level_o); else passed++;
    endtask

    task automatic test_glitch;
        int  start;
        logic busy_seen;
        debounce_cycles_i = 16'd4; edge_sel_i = 2'b01; en_i = 1'b1;
        tick(2);
        start = pulse_cnt;
        busy_seen = 1'b0;
        evt_i = 1'b1;
        tick(3);
        evt_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (busy_o === 1'b1) busy_seen = 1'b1;
            if (level_o !== 1'b0) busy_seen = 1'bx;
        end
        checks++; if (busy_seen !== 1'b1) $display("FAIL glitch3_busy_seen: got %b expected 1", busy_seen); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL glitch3_busy_end: got %b expected 0", busy_o); else passed++;
        checks++; if (level_o !== 1'b0) $display("FAIL glitch3_level: got %b expected 0", level_o); else passed++;
        checks++; if (pulse_cnt - start !== 0) $display("FAIL glitch3_pulses: got %0d expected 0", pulse_cnt - start); else passed++;

        start = pulse_cnt;
        evt_i = 1'b1;
        tick(4);               // after k+3
        evt_i = 1'b0;
        tick(2);               // after k+5: rising commit
        checks++; if (level_o !== 1'b1) $display("FAIL glitch4_level_high: got %b expected 1", level_o); else passed++;
        checks++; if (pulse_o !== 1'b1) $display("FAIL glitch4_pulse: got %b expected 1", pulse_o); else passed++;
        tick(10);
        checks++; if (level_o !== 1'b0) $display("FAIL glitch4_level_fall: got %b expected 0", level_o); else passed++;
        checks++; if (pulse_cnt - start !== 1) $display("FAIL glitch4_pulses: got %0d expected 1", pulse_cnt - start); else passed++;
    endtask

    task automatic test_edge_sel;
        logic [1:0] sel_tab [4] = '{2'b11, 2'b10, 2'b00, 2'b11};
        logic       en_tab  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int         rise_exp[4] = '{1, 0, 0, 0};
        int         fall_exp[4] = '{1, 1, 0, 0};
        int         start;
        debounce_cycles_i = 16'd2;
        for (int t = 0; t < 4; t++) begin
            edge_sel_i = sel_tab[t]; en_i = en_tab[t];
            tick(1);
            start = pulse_cnt;
            evt_i = 1'b1;
            tick(8);
            checks++; if (level_o !== 1'b1) $display("FAIL edgesel%0d_level_high: got %b expected 1", t, level_o); else passed++;
            checks++; if (pulse_cnt - start !== rise_exp[t]) $display("FAIL edgesel%0d_rise_pulses: got %0d expected %0d", t, pulse_cnt - start, rise_exp[t]); else passed++;
            start = pulse_cnt;
            evt_i = 1'b0;
            tick(8);
            checks++; if (level_o !== 1'b0) $display("FAIL edgesel%0d_level_low: got %b expected 0", t, level_o); else passed++;
            checks++; if (pulse_cnt - start !== fall_exp[t]) $display("FAIL edgesel%0d_fall_pulses: got %0d expected %0d", t, pulse_cnt - start, fall_exp[t]); else passed++;
        end
        en_i = 1'b1;
    endtask

    task automatic test_back_to_back;
        int start;
        debounce_cycles_i = 16'd0; edge_sel_i = 2'b11; en_i = 1'b1;
        tick(2);
        start = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            evt_i = ~evt_i;
            tick(1);
            if (i > 0) begin
                // Previous toggle commits two edges after its capture edge.
                checks++; if (pulse_o !== 1'b1 || level_o !== ~evt_i) $display("FAIL b2b_pulse%0d: got pulse=%b level=%b expected pulse=1 level=%b", i - 1, pulse_o, level_o, ~evt_i); else passed++;
            end
            tick(1);
            checks++; if (pulse_o !== 1'b0) $display("FAIL b2b_gap%0d: got %b expected 0", i, pulse_o); else passed++;
        end
        tick(1);
        checks++; if (pulse_o !== 1'b1 || level_o !== evt_i) $display("FAIL b2b_pulse7: got pulse=%b level=%b expected pulse=1 level=%b", pulse_o, level_o, evt_i); else passed++;
        tick(3);
        checks++; if (pulse_cnt - start !== 8) $display("FAIL b2b_total: got %0d expected 8", pulse_cnt - start); else passed++;
    endtask

    task automatic test_hold_change;
        int start;
        debounce_cycles_i = 16'd100; edge_sel_i = 2'b01; en_i = 1'b1;
        tick(2);
        evt_i = 1'b1;
        tick(12);              // after k+11: cnt = 10
        checks++; if (busy_o !== 1'b1 || level_o !== 1'b0) $display("FAIL hold_mid: got busy=%b level=%b expected busy=1 level=0", busy_o, level_o); else passed++;
        debounce_cycles_i = 16'd5;
        tick(1);
        checks++; if ({busy_o, level_o, pulse_o} !== 3'b011) $display("FAIL hold_lowered_commit: got %b expected 011", {busy_o, level_o, pulse_o}); else passed++;
        evt_i = 1'b0;
        tick(10);
        checks++; if (level_o !== 1'b0) $display("FAIL hold_fall: got %b expected 0", level_o); else passed++;

        // Reset during a long qualification.
        debounce_cycles_i = 16'd100;
        evt_i = 1'b1;
        tick(52);              // after k+51: cnt = 50
        checks++; if (busy_o !== 1'b1) $display("FAIL rst_mid_busy_before: got %b expected 1", busy_o); else passed++;
        #2 rst_i = 1'b1;
        #1;
        checks++; if ({busy_o, level_o, pulse_o} !== 3'b000) $display("FAIL rst_mid_async: got %b expected 000", {busy_o, level_o, pulse_o}); else passed++;
        evt_i = 1'b0;
        tick(2);
        rst_i = 1'b0;
        start = pulse_cnt;
        tick(110);
        checks++; if (pulse_cnt - start !== 0 || level_o !== 1'b0) $display("FAIL rst_mid_after: got pulses=%0d level=%b expected pulses=0 level=0", pulse_cnt - start, level_o); else passed++;
    endtask

    task automatic test_counter;
        int start;
        debounce_cycles_i = 16'd2; edge_sel_i = 2'b01; en_i = 1'b1;
        tick(2);
        start = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            evt_i = 1'b1;
            tick(6);
            evt_i = 1'b0;
            tick(6);
        end
        checks++; if (pulse_cnt - start !== 10) $display("FAIL counter_value: got %0d expected 10", pulse_cnt - start); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_i = 1'b1; evt_i = 1'b0; en_i = 1'b0; edge_sel_i = 2'b00; debounce_cycles_i = '0;
        test_reset;
        test_basic_rise;
        test_glitch;
        test_edge_sel;
        test_back_to_back;
        test_hold_change;
        test_counter;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/event_conditioner.md
# event_conditioner

Input-conditioning stage that sits directly upstream of the parameterised event counter. Takes a raw, asynchronous event line, synchronises it into the clock domain, debounces it with a programmable hold time, and detects selected edges. Each accepted edge is emitted as a single-cycle `pulse_o`, which drives the counter's increment input. Also exports the debounced level and a busy indication for software polling.

## Interface

Parameters:
- `DEBOUNCE_WIDTH`, default 16: width of the debounce hold counter and of `debounce_cycles_i`.
- `SYNC_STAGES`, default 2: synchronizer flop count. Legal range is 2 to 4.

Ports:
- `clk_i`, input, 1: the single clock. All state updates on its rising edge.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `evt_i`, input, 1: raw event line. It is asynchronous to `clk_i`.
- `en_i`, input, 1: pulse enable. When 0, debouncing continues but `pulse_o` is suppressed.
- `edge_sel_i`, input, 2: edge select.
  - 00: none
  - 01: rising
  - 10: falling
  - 11: both
- `debounce_cycles_i`, input, `DEBOUNCE_WIDTH`: hold count N.
- `pulse_o`, output, 1: one-cycle pulse per accepted selected edge. Feeds the counter's `inc_i`.
- `level_o`, output, 1: debounced level.
- `busy_o`, output, 1: high while a candidate transition is being qualified.

## Operation

- **Synchronizer.**
  - `evt_i` passes through a `SYNC_STAGES` flop chain.
  - `s_evt` is the last stage of the chain.
  - No other logic samples `evt_i`.
- **Effective hold count.** Neff = N when N ≥ 1. Neff = 1 when N = 0.
- **FSM states:** IDLE and QUALIFY. There is one hold counter `cnt` of width `DEBOUNCE_WIDTH`.
- **IDLE:**
  - If `s_evt` equals `level_q`: stay in IDLE, `cnt` = 0.
  - If `s_evt` differs and Neff = 1: commit (see below) and stay in IDLE.
  - If `s_evt` differs and Neff > 1: go to QUALIFY with `cnt` = 1.
- **QUALIFY:**
  - If `s_evt` equals `level_q` (glitch): return to IDLE, `cnt` = 0, no commit, no pulse.
  - Else if `cnt` + 1 ≥ Neff: commit, return to IDLE, `cnt` = 0.
  - Else `cnt` increments.
- **Commit:** `level_q` is inverted. The edge is rising if the new `level_q` = 1, falling otherwise.
- **Pulse:** `pulse_o` is registered. It is 1 for exactly the cycle following the commit edge when both hold:
  - `en_i` = 1 at the commit edge;
  - the edge matches `edge_sel_i`.
  
  Otherwise it is 0.
- **Hold count changes:** `debounce_cycles_i` is sampled every cycle. If it is lowered mid-QUALIFY so that `cnt` + 1 ≥ Neff, the commit happens on the next edge. The `>=` compare exists for this case; the counter can never overflow.
- **`edge_sel_i` and `en_i`** are evaluated only at the commit edge. Changing them mid-QUALIFY does not disturb qualification.
- **Reset state:** `level_q` = 0.
  - If `evt_i` is held high through reset release, it qualifies as a rising edge and pulses, provided it is enabled and selected.

## Timing

- **Reset values:** `pulse_o` = 0, `level_o` = 0, `busy_o` = 0. The sync chain is 0, the state is IDLE, `cnt` = 0.
- **Reset is asynchronous.** Asserting `rst_i` mid-QUALIFY aborts the qualification immediately. No pulse is produced.
- **Latency.** Let edge k be the first clock edge at which the sync chain's first flop captures a new, stable `evt_i` value. Then:
  - `level_o` changes at edge k + `SYNC_STAGES` + Neff − 1;
  - `pulse_o` is high for the cycle after that edge, i.e. it rises with `level_o`.
  - Example: with `SYNC_STAGES` = 2 and N = 3, the change appears at edge k+4.
- **`busy_o`** = (state == QUALIFY). It is registered with the state.
- **Minimum spacing.** Two committed edges are at least Neff cycles apart, so `pulse_o` is never high on consecutive cycles when Neff ≥ 2. With Neff = 1, back-to-back alternating toggles can pulse every cycle when `edge_sel_i` = 11.
- **Glitch filtering.** A glitch of width g synchronized cycles, with g < Neff, produces no change on `level_o`, `pulse_o` or the counter.

## Structure

- **Shared package `evt_cond_pkg`:**
  - state enum `{IDLE, QUALIFY}`;
  - edge-select constants `EDGE_NONE`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`.
- **Sub-module `sync_chain`:**
  - parameter `STAGES`, 1-bit data;
  - asynchronous active-high reset clears every stage to 0;
  - reusable elsewhere in the primitives library.
- **`event_conditioner`** instantiates `sync_chain` and contains the FSM, the hold counter and the edge/pulse logic.

## Test plan

1. **Reset and basic rise.** Assert `rst_i`, then release it with `evt_i` = 0, N = 3, `edge_sel_i` = 01, `en_i` = 1. Raise `evt_i` before edge k.
   - Required: `busy_o` high from edge k+2; `level_o` = 1 and a single-cycle `pulse_o` at edge k+4; all outputs 0 during reset.
2. **Glitch rejection.** N = 4. Apply a `evt_i` high pulse lasting 3 clocks.
   - Required: `busy_o` goes high then drops; `level_o` stays 0; no `pulse_o`.
   - Repeat with a 4-clock pulse: exactly one rising pulse and one falling commit, with no falling pulse since `edge_sel_i` = 01.
3. **Edge select and enable.**
   - Toggle `evt_i` 0→1→0 with `edge_sel_i` = 11: 2 pulses.
   - With `edge_sel_i` = 10: 1 pulse, on the fall.
   - With `edge_sel_i` = 00: 0 pulses.
   - With `en_i` = 0 and `edge_sel_i` = 11: 0 pulses, but `level_o` still tracks.
4. **N = 0 and back-to-back.** N = 0, `edge_sel_i` = 11. Toggle the synchronized input every 2 cycles for 8 toggles.
   - Required: 8 pulses, each at latency k+2.
5. **Hold count lowered and reset mid-operation.**
   - N = 100 in QUALIFY with `cnt` = 10; set N = 5: commit on the next edge.
   - Separately, assert `rst_i` with `cnt` = 50: outputs go to 0 immediately and no pulse appears after release with `evt_i` = 0.
6. **Counter integration.** Connect `pulse_o` to the counter's `inc_i` and apply 10 clean rising edges with N = 2.
   - Required: counter value = 10.
